text_console_writer: RTL and testbench
======================================

Name: text_console_writer

Overview:
- Writer side of the 40x30 text-mode display memory; the character renderer is the reader.
- Accepts a byte stream from the CPU/bus over a valid/ready handshake.
- Writes printable characters at a hardware cursor and interprets control codes.
- Performs scroll-up and clear-screen by sequencing through its own single display-memory port.

Parameters:
- COLS, 40, characters per row.
- ROWS, 30, rows per screen.
- ADDR_W, 12, display-memory address width.
- FILL_CHAR, 8'h20, code written into blanked cells (space).

Ports:
- clk  in  1  system clock
- clr  in  1  asynchronous reset, active-low
- in_data  in  8  character/control byte
- in_valid  in  1  in_data valid
- in_ready  out  1  block can accept a byte
- dm_addr  out  ADDR_W  display-memory address, row*COLS+col
- dm_wdata  out  8  display-memory write data
- dm_we  out  1  write strobe, one cycle per write
- dm_re  out  1  read strobe
- dm_rdata  in  8  read data, valid exactly one cycle after dm_re
- cursor_x  out  6  current column, 0..COLS-1
- cursor_y  out  5  current row, 0..ROWS-1
- busy  out  1  scroll or clear sequence in progress

Behaviour:
- Reset: clr low asynchronously forces state IDLE, cursor 0,0, dm_we=0, dm_re=0, dm_addr=0, dm_wdata=0, busy=0, in_ready=0.
  - in_ready rises on the first clk edge after clr deasserts.
  - Reset in mid-sequence abandons the sequence; memory contents are left as-is.
- Handshake: a byte is accepted on a clk edge with in_valid && in_ready. in_ready is high only in IDLE and drops the cycle after an accept.
- All outputs are registered. States: IDLE, PUT, SCR_RD, SCR_WR, FILL, CLR_ALL.
- Printable byte (0x20..0x7E, 0x80..0xFF): PUT asserts dm_we=1 for one cycle with dm_addr=cursor_y*COLS+cursor_x and dm_wdata=byte. The write occurs the cycle after accept.
  - Cursor advances in the same cycle: x+1.
  - If x was COLS-1: x=0, y+1.
  - If y was ROWS-1 on that wrap: y stays ROWS-1 and the block enters SCR_RD.
  - Otherwise it returns to IDLE.
- 0x0D (CR): x=0.
- 0x0A (LF): x=0, y+1; scrolls if y was ROWS-1.
- 0x08 (BS): if x>0, x-1 and FILL_CHAR is written at the new position. At x=0 the cursor is unchanged and no write occurs; it never wraps to the previous row.
- 0x0C (FF): CLR_ALL, then cursor 0,0.
- 0x09: see the optional feature below.
- Other codes 0x00..0x1F and 0x7F: consumed, no effect, 1 cycle back to IDLE.
- Scroll, source addresses s = COLS..COLS*ROWS-1 ascending:
  - SCR_RD: dm_re=1, dm_addr=s.
  - SCR_WR (next cycle): dm_we=1, dm_addr=s-COLS, dm_wdata=dm_rdata.
  - 2 cycles per cell, 2*(ROWS-1)*COLS = 2320 cycles.
- FILL: writes FILL_CHAR to row ROWS-1, one cell per cycle (40 cycles), then IDLE.
- CLR_ALL: writes FILL_CHAR to addresses 0..COLS*ROWS-1, one per cycle (1200 cycles).
- busy=1 throughout SCR_RD/SCR_WR/FILL/CLR_ALL. dm_we and dm_re are never asserted together.
- Address arithmetic is done at ADDR_W width; the maximum address is 1199, so there is no overflow.
- The cursor never leaves the 0..COLS-1 / 0..ROWS-1 range.

Optional Feature:
- Macro: TEXT_TAB_EXPAND_EN.
- Defined: 0x09 advances x to the next multiple of 8, writing FILL_CHAR to each skipped cell, one per cycle. Reaching COLS performs the same wrap/scroll as a printable byte at COLS-1.
- Undefined: 0x09 is treated as an ignored control code.

Decomposition:
- Shared package text_pkg: COLS, ROWS, ADDR_W, FILL_CHAR, control-code constants (CC_BS, CC_TAB, CC_LF, CC_FF, CC_CR), and the state enum.
- One natural sub-module: text_addr_calc, the combinational row*COLS+col (shift-add, y<<5 + y<<3 + x), reused for cursor writes and fill addressing.

Test Plan:
- Reset, then send 'A' (0x41) -> one cycle after accept: dm_we=1, dm_addr=0, dm_wdata=0x41; cursor_x=1.
- Cursor at 5,2, send 0x0D then 0x0A -> cursor 0,3, no dm_we.
- Cursor at 39,29, send 'Z' -> write at 1199, then busy for 2320+40 cycles. First pair: read 40 / write 0. Last FILL write is addr 1199 = 0x20. Cursor ends at 0,29 and in_ready returns high.
- Send 0x0C -> 1200 consecutive writes of 0x20 to addresses 0..1199, cursor 0,0.
- Cursor 0,4, send 0x08 -> no write, cursor unchanged. Cursor 3,4, send 0x08 -> write 0x20 at addr 162, cursor 2,4.
- Pull clr low mid-scroll (cycle ~500) -> outputs return to reset values immediately; after release, 'B' writes at addr 0.

Source files
------------

// File: rtl/text_pkg.sv
// rtl/text_pkg.sv - shared geometry, control codes and state encoding for the text console writer
package text_pkg;

   localparam int COLS   = 40;
   localparam int ROWS   = 30;
   localparam int ADDR_W = 12;

   localparam logic [7:0] FILL_CHAR = 8'h20;

   localparam logic [7:0] CC_BS  = 8'h08;
   localparam logic [7:0] CC_TAB = 8'h09;
   localparam logic [7:0] CC_LF  = 8'h0A;
   localparam logic [7:0] CC_FF  = 8'h0C;
   localparam logic [7:0] CC_CR  = 8'h0D;

   localparam logic [5:0]        LAST_COL  = 6'(COLS - 1);
   localparam logic [4:0]        LAST_ROW  = 5'(ROWS - 1);
   localparam logic [ADDR_W-1:0] COLS_A    = ADDR_W'(COLS);
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(COLS * ROWS - 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_PUT,
      ST_SCR_RD,
      ST_SCR_WR,
      ST_FILL,
      ST_CLR_ALL
   } state_t;

   // 0x20..0x7E and 0x80..0xFF land in display memory; everything else is a control code
   function automatic logic is_printable(input logic [7:0] b);
      return (b >= 8'h20) && (b != 8'h7F);
   endfunction

endpackage

// File: rtl/text_addr_calc.sv
// rtl/text_addr_calc.sv - combinational row*40+col display-memory address
module text_addr_calc
   import text_pkg::*;
(
   input  logic [5:0]        col,
   input  logic [4:0]        row,
   output logic [ADDR_W-1:0] addr
);

   // row*40 = row*32 + row*8, kept as shifts so no multiplier is inferred
   assign addr = ADDR_W'({row, 5'b0}) + ADDR_W'({row, 3'b0}) + ADDR_W'(col);

endmodule

// File: rtl/text_console_writer.sv
// rtl/text_console_writer.sv - byte-stream writer for the 40x30 text display memory (optional TEXT_TAB_EXPAND_EN)
module text_console_writer
   import text_pkg::*;
(
   input  logic              clk,
   input  logic              clr,
   input  logic [7:0]        in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [ADDR_W-1:0] dm_addr,
   output logic [7:0]        dm_wdata,
   output logic              dm_we,
   output logic              dm_re,
   input  logic [7:0]        dm_rdata,
   output logic [5:0]        cursor_x,
   output logic [4:0]        cursor_y,
   output logic              busy
);

   state_t            state;
   logic [7:0]        wdata_q;
   logic              scroll_pend;
   logic [5:0]        fill_col;
   logic [5:0]        fill_nxt;
   logic [ADDR_W-1:0] src;
   logic              tab_mode;

   logic [5:0]        calc_col;
   logic [4:0]        calc_row;
   logic [ADDR_W-1:0] calc_addr;

   logic [5:0]        adv_x;
   logic [4:0]        adv_y;
   logic              adv_scroll;

`ifndef TEXT_TAB_EXPAND_EN
   assign tab_mode = 1'b0;
`endif

   // During a scroll the read data only exists in the write cycle, so it is passed straight through
   assign dm_wdata = (state == ST_SCR_WR) ? dm_rdata : wdata_q;

   text_addr_calc u_addr (
      .col  (calc_col),
      .row  (calc_row),
      .addr (calc_addr)
   );

   // Cursor position after writing one cell, including row wrap and scroll request
   always_comb begin
      adv_x      = cursor_x + 6'd1;
      adv_y      = cursor_y;
      adv_scroll = 1'b0;
      if (cursor_x == LAST_COL) begin
         adv_x = 6'd0;
         if (cursor_y == LAST_ROW) adv_scroll = 1'b1;
         else                      adv_y      = cursor_y + 5'd1;
      end
   end

   // Address source: the cursor normally, the next bottom-row cell while blanking after a scroll
   always_comb begin
      fill_nxt = (state == ST_FILL) ? fill_col + 6'd1 : 6'd0;
      calc_col = cursor_x;
      calc_row = cursor_y;
      if (state == ST_SCR_WR || state == ST_FILL) begin
         calc_col = fill_nxt;
         calc_row = LAST_ROW;
      end
   end

   // Main sequencer: byte intake, cursor handling, scroll copy, bottom-row fill and full clear
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         state       <= ST_IDLE;
         in_ready    <= 1'b0;
         dm_addr     <= '0;
         wdata_q     <= 8'h00;
         dm_we       <= 1'b0;
         dm_re       <= 1'b0;
         cursor_x    <= 6'd0;
         cursor_y    <= 5'd0;
         busy        <= 1'b0;
         scroll_pend <= 1'b0;
         fill_col    <= 6'd0;
         src         <= '0;
`ifdef TEXT_TAB_EXPAND_EN
         tab_mode    <= 1'b0;
`endif
      end else begin
         case (state)
            ST_IDLE: begin
               if (in_valid && in_ready) begin
                  in_ready    <= 1'b0;
                  state       <= ST_PUT;
                  scroll_pend <= 1'b0;
                  wdata_q     <= in_data;
                  if (is_printable(in_data)) begin
                     dm_we       <= 1'b1;
                     dm_addr     <= calc_addr;
                     cursor_x    <= adv_x;
                     cursor_y    <= adv_y;
                     scroll_pend <= adv_scroll;
                  end else begin
                     case (in_data)
                        CC_CR: cursor_x <= 6'd0;
                        CC_LF: begin
                           cursor_x <= 6'd0;
                           if (cursor_y == LAST_ROW) scroll_pend <= 1'b1;
                           else                      cursor_y    <= cursor_y + 5'd1;
                        end
                        CC_BS: begin
                           if (cursor_x != 6'd0) begin
                              cursor_x <= cursor_x - 6'd1;
                              dm_we    <= 1'b1;
                              dm_addr  <= calc_addr - ADDR_W'(1);
                              wdata_q  <= FILL_CHAR;
                           end
                        end
                        CC_FF: begin
                           state   <= ST_CLR_ALL;
                           dm_we   <= 1'b1;
                           dm_addr <= '0;
                           wdata_q <= FILL_CHAR;
                           busy    <= 1'b1;
                        end
`ifdef TEXT_TAB_EXPAND_EN
                        CC_TAB: begin
                           tab_mode    <= 1'b1;
                           dm_we       <= 1'b1;
                           dm_addr     <= calc_addr;
                           wdata_q     <= FILL_CHAR;
                           cursor_x    <= adv_x;
                           cursor_y    <= adv_y;
                           scroll_pend <= adv_scroll;
                        end
`endif
                        default: ;
                     endcase
                  end
               end else begin
                  in_ready <= 1'b1;
               end
            end

            ST_PUT: begin
               dm_we <= 1'b0;
               if (scroll_pend) begin
                  state       <= ST_SCR_RD;
                  dm_re       <= 1'b1;
                  dm_addr     <= COLS_A;
                  src         <= COLS_A;
                  busy        <= 1'b1;
                  scroll_pend <= 1'b0;
`ifdef TEXT_TAB_EXPAND_EN
                  tab_mode    <= 1'b0;
`endif
               end else if (tab_mode && cursor_x[2:0] != 3'd0) begin
                  dm_we       <= 1'b1;
                  dm_addr     <= calc_addr;
                  cursor_x    <= adv_x;
                  cursor_y    <= adv_y;
                  scroll_pend <= adv_scroll;
               end else begin
                  state    <= ST_IDLE;
                  in_ready <= 1'b1;
`ifdef TEXT_TAB_EXPAND_EN
                  tab_mode <= 1'b0;
`endif
               end
            end

            ST_SCR_RD: begin
               state   <= ST_SCR_WR;
               dm_re   <= 1'b0;
               dm_we   <= 1'b1;
               dm_addr <= src - COLS_A;
            end

            ST_SCR_WR: begin
               if (src == LAST_ADDR) begin
                  state    <= ST_FILL;
                  dm_we    <= 1'b1;
                  dm_addr  <= calc_addr;
                  wdata_q  <= FILL_CHAR;
                  fill_col <= 6'd0;
               end else begin
                  state   <= ST_SCR_RD;
                  dm_we   <= 1'b0;
                  dm_re   <= 1'b1;
                  dm_addr <= src + ADDR_W'(1);
                  src     <= src + ADDR_W'(1);
               end
            end

            ST_FILL: begin
               if (fill_col == LAST_COL) begin
                  state    <= ST_IDLE;
                  dm_we    <= 1'b0;
                  busy     <= 1'b0;
                  in_ready <= 1'b1;
               end else begin
                  fill_col <= fill_nxt;
                  dm_addr  <= calc_addr;
               end
            end

            ST_CLR_ALL: begin
               if (dm_addr == LAST_ADDR) begin
                  state    <= ST_IDLE;
                  dm_we    <= 1'b0;
                  busy     <= 1'b0;
                  in_ready <= 1'b1;
                  cursor_x <= 6'd0;
                  cursor_y <= 5'd0;
               end else begin
                  dm_addr <= dm_addr + ADDR_W'(1);
               end
            end

            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_text_console_writer.sv
// tb/tb_text_console_writer.sv - directed self-checking bench for text_console_writer
module tb_text_console_writer;

   logic        clk;
   logic        clr;
   logic [7:0]  in_data;
   logic        in_valid;
   logic        in_ready;
   logic [11:0] dm_addr;
   logic [7:0]  dm_wdata;
   logic        dm_we;
   logic        dm_re;
   logic [7:0]  dm_rdata;
   logic [5:0]  cursor_x;
   logic [4:0]  cursor_y;
   logic        busy;

   logic [7:0]  mem [0:1199] = '{default: 8'h00};
   int          wr_cnt  = 0;
   int          overlap = 0;
   int          last_wa = 0;
   int          last_wd = 0;

   int          n_total = 0;
   int          n_bad   = 0;

   text_console_writer dut (
      .clk      (clk),
      .clr      (clr),
      .in_data  (in_data),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .dm_addr  (dm_addr),
      .dm_wdata (dm_wdata),
      .dm_we    (dm_we),
      .dm_re    (dm_re),
      .dm_rdata (dm_rdata),
      .cursor_x (cursor_x),
      .cursor_y (cursor_y),
      .busy     (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // display memory with one-cycle read latency, plus write bookkeeping
   always @(posedge clk) begin
      if (dm_re) dm_rdata <= mem[dm_addr];
      if (dm_we) begin
         mem[dm_addr] <= dm_wdata;
         wr_cnt       <= wr_cnt + 1;
         last_wa      <= int'(dm_addr);
         last_wd      <= int'(dm_wdata);
      end
      if (dm_we && dm_re) overlap <= overlap + 1;
   end

   task automatic check_eq(input string tag, input int got, input int exp);
      n_total++;
      if (got != exp) begin
         n_bad++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic wait_ready();
      int n = 0;
      while (!in_ready && n < 5000) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) check_eq("ready_timeout", int'(in_ready), 1);
   endtask

   // returns at the negedge of the cycle after acceptance
   task automatic send(input logic [7:0] b);
      wait_ready();
      in_data  = b;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   initial begin
      int base;
      int n;
      int bad_seq;
      int exp_x;
      int exp_w;

      clr      = 1'b0;
      in_valid = 1'b0;
      in_data  = 8'h00;
      dm_rdata = 8'h00;
      repeat (3) @(negedge clk);

      // reset state
      check_eq("rst_ready", int'(in_ready), 0);
      check_eq("rst_we",    int'(dm_we),    0);
      check_eq("rst_re",    int'(dm_re),    0);
      check_eq("rst_addr",  int'(dm_addr),  0);
      check_eq("rst_wdata", int'(dm_wdata), 0);
      check_eq("rst_busy",  int'(busy),     0);
      check_eq("rst_cx",    int'(cursor_x), 0);
      check_eq("rst_cy",    int'(cursor_y), 0);
      clr = 1'b1;
      #1 check_eq("rel_ready_lo", int'(in_ready), 0);
      @(negedge clk);
      check_eq("rel_ready_hi", int'(in_ready), 1);

      // printable 'A' at 0,0
      send(8'h41);
      check_eq("a_we",    int'(dm_we),    1);
      check_eq("a_addr",  int'(dm_addr),  0);
      check_eq("a_wdata", int'(dm_wdata), 8'h41);
      check_eq("a_cx",    int'(cursor_x), 1);
      check_eq("a_ready", int'(in_ready), 0);
      @(negedge clk);
      check_eq("a_we_off", int'(dm_we),    0);
      check_eq("a_idle",   int'(in_ready), 1);

      // walk to 5,2 then CR, LF
      send(8'h0D);
      send(8'h0A);
      send(8'h0A);
      for (int i = 0; i < 5; i++) send(8'h62 + 8'(i));
      wait_ready();
      check_eq("pos_cx", int'(cursor_x), 5);
      check_eq("pos_cy", int'(cursor_y), 2);
      base = wr_cnt;
      send(8'h0D);
      check_eq("cr_cx", int'(cursor_x), 0);
      check_eq("cr_cy", int'(cursor_y), 2);
      send(8'h0A);
      wait_ready();
      check_eq("lf_cx",  int'(cursor_x), 0);
      check_eq("lf_cy",  int'(cursor_y), 3);
      check_eq("crlf_w", wr_cnt - base, 0);

      // backspace at column 0, then at column 3
      send(8'h0A);
      base = wr_cnt;
      send(8'h08);
      wait_ready();
      check_eq("bs0_cx", int'(cursor_x), 0);
      check_eq("bs0_cy", int'(cursor_y), 4);
      check_eq("bs0_w",  wr_cnt - base, 0);
      send(8'h78);
      send(8'h79);
      send(8'h7A);
      send(8'h08);
      check_eq("bs_we",    int'(dm_we),    1);
      check_eq("bs_addr",  int'(dm_addr),  162);
      check_eq("bs_wdata", int'(dm_wdata), 8'h20);
      check_eq("bs_cx",    int'(cursor_x), 2);
      check_eq("bs_cy",    int'(cursor_y), 4);
      wait_ready();
      check_eq("bs_mem", int'(mem[162]), 8'h20);

      // ignored control code, then tab
      base = wr_cnt;
      send(8'h07);
      check_eq("ign_ready", int'(in_ready), 0);
      @(negedge clk);
      check_eq("ign_back", int'(in_ready), 1);
      check_eq("ign_cx",   int'(cursor_x), 2);
      check_eq("ign_w",    wr_cnt - base, 0);
`ifdef TEXT_TAB_EXPAND_EN
      exp_x = 8;
      exp_w = 6;
`else
      exp_x = 2;
      exp_w = 0;
`endif
      base = wr_cnt;
      send(8'h09);
      wait_ready();
      check_eq("tab_cx", int'(cursor_x), exp_x);
      check_eq("tab_w",  wr_cnt - base, exp_w);

      // form feed clears the whole screen
      send(8'h0C);
      n       = 0;
      bad_seq = 0;
      while (busy && n < 3000) begin
         if (!dm_we || int'(dm_addr) != n || dm_wdata != 8'h20 || dm_re) bad_seq++;
         n++;
         @(negedge clk);
      end
      check_eq("clr_cycles", n, 1200);
      check_eq("clr_seq",    bad_seq, 0);
      check_eq("clr_cx",     int'(cursor_x), 0);
      check_eq("clr_cy",     int'(cursor_y), 0);
      check_eq("clr_ready",  int'(in_ready), 1);
      check_eq("clr_mem0",   int'(mem[0]),   8'h20);

      // fill screen to 39,29 with a marker on row 1, then overflow
      send(8'h0A);
      send(8'h51);
      send(8'h52);
      for (int i = 0; i < 28; i++) send(8'h0A);
      for (int i = 0; i < 39; i++) send(8'h6B);
      wait_ready();
      check_eq("pre_cx", int'(cursor_x), 39);
      check_eq("pre_cy", int'(cursor_y), 29);
      send(8'h5A);
      check_eq("z_we",    int'(dm_we),    1);
      check_eq("z_addr",  int'(dm_addr),  1199);
      check_eq("z_wdata", int'(dm_wdata), 8'h5A);
      @(negedge clk);
      check_eq("scr_re",    int'(dm_re),   1);
      check_eq("scr_raddr", int'(dm_addr), 40);
      check_eq("scr_busy",  int'(busy),    1);
      @(negedge clk);
      check_eq("scr_we",    int'(dm_we),    1);
      check_eq("scr_waddr", int'(dm_addr),  0);
      check_eq("scr_wdata", int'(dm_wdata), 8'h51);
      n = 2;
      @(negedge clk);
      while (busy && n < 5000) begin
         n++;
         @(negedge clk);
      end
      check_eq("scr_cycles", n, 2360);
      check_eq("fill_la",    last_wa, 1199);
      check_eq("fill_ld",    last_wd, 8'h20);
      check_eq("scr_cx",     int'(cursor_x), 0);
      check_eq("scr_cy",     int'(cursor_y), 29);
      check_eq("scr_ready",  int'(in_ready), 1);
      check_eq("mem_0",      int'(mem[0]),    8'h51);
      check_eq("mem_1",      int'(mem[1]),    8'h52);
      check_eq("mem_1120",   int'(mem[1120]), 8'h6B);
      check_eq("mem_1159",   int'(mem[1159]), 8'h5A);
      check_eq("mem_1160",   int'(mem[1160]), 8'h20);
      check_eq("mem_1199",   int'(mem[1199]), 8'h20);

      // LF on the last row scrolls; abort it with reset
      send(8'h0A);
      repeat (500) @(negedge clk);
      check_eq("mid_busy", int'(busy), 1);
      clr = 1'b0;
      #1;
      check_eq("ar_we",    int'(dm_we),    0);
      check_eq("ar_re",    int'(dm_re),    0);
      check_eq("ar_addr",  int'(dm_addr),  0);
      check_eq("ar_wdata", int'(dm_wdata), 0);
      check_eq("ar_busy",  int'(busy),     0);
      check_eq("ar_ready", int'(in_ready), 0);
      check_eq("ar_cx",    int'(cursor_x), 0);
      check_eq("ar_cy",    int'(cursor_y), 0);
      @(negedge clk);
      clr = 1'b1;
      @(negedge clk);
      check_eq("ar_rel_ready", int'(in_ready), 1);
      send(8'h42);
      check_eq("b_we",    int'(dm_we),    1);
      check_eq("b_addr",  int'(dm_addr),  0);
      check_eq("b_wdata", int'(dm_wdata), 8'h42);
      check_eq("b_cx",    int'(cursor_x), 1);

      check_eq("we_re_excl", overlap, 0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
